input_mapper: RTL and testbench
===============================

// Module: input_mapper
//
// PURPOSE
// Generalised player-input front end for arcade cores. Merges PS/2 keyboard
// and hps_io joystick words for up to 4 players into registered per-player
// direction/button/start/coin lanes, plus a global pause. Adds coin pulse
// stretching and per-player autofire. Also latches DIP bytes and the game
// index from ioctl. Sits between hps_io and the game core in the emu top.
//
// PARAMETERS
// NUM_PLAYERS   2      players, 1..4. Keyboard maps players 0-1 only.
// NUM_BUTTONS   3      fire buttons per player, 1..6. JOY_W = 7+NUM_BUTTONS (localparam).
// COIN_PULSE    960000 minimum coin-high time in clk cycles; 0 = no stretch.
// AUTOFIRE_HALF 1600000 autofire half-period in clk cycles; must be >= 1.
// DIP_COUNT     8      DIP bytes stored, 1..8.
//
// PORTS
// clk          in   1                     system clock
// reset_n      in   1                     async active-low reset; power-on/PLL-lock only, never game reset
// ps2_key      in   11                    [10] toggle, [9] pressed, [8] extended (ignored), [7:0] scancode
// joystick     in   NUM_PLAYERS*JOY_W     player p at [p*JOY_W +: JOY_W]
// autofire_en  in   NUM_PLAYERS           per-player autofire on button 0
// ioctl_wr     in   1                     ioctl write strobe
// ioctl_index  in   8                     ioctl target
// ioctl_addr   in   25                    ioctl byte address
// ioctl_data   in   8                     ioctl byte
// dir          out  NUM_PLAYERS*4         per player {up,down,right,left}
// fire         out  NUM_PLAYERS*NUM_BUTTONS per player, bit 0 = button 1
// start        out  NUM_PLAYERS           start per player
// coin         out  NUM_PLAYERS           stretched coin per player
// pause        out  1                     OR of all players' pause
// dip          out  DIP_COUNT*8           byte i at [i*8 +: 8]
// game_index   out  4                     selected game variant
//
// BEHAVIOUR
// - Reset: all outputs, key flags, counters 0; autofire phase 1; primed 0.
// - Joystick word bits: [0] right [1] left [2] down [3] up,
//   [4 +: NUM_BUTTONS] fire, then start, coin, pause.
// - PS/2: old_toggle reg; first cycle after reset sets primed and loads
//   old_toggle, no event. Thereafter event when ps2_key[10] != old_toggle;
//   matching key flag <= ps2_key[9]. Unknown codes ignored. P0: arrows
//   75/72/6B/74, fire 14/11/29, start 16, coin 2E, pause 4D. P1: R/F/D/G
//   2D/2B/23/34, fire 1C/1B/15, start 1E, coin 36. Fire keys beyond
//   NUM_BUTTONS unused.
// - Raw lane = key flag | joystick bit. Outputs registered: joystick change
//   at edge k visible after edge k+1; PS/2 toggle at edge k after edge k+2.
// - Coin: per-player down-counter. Raw coin rising edge loads COIN_PULSE,
//   including retrigger mid-count. coin = raw | (cnt != 0). Counter
//   saturates at 0.
// - Autofire: shared counter 0..AUTOFIRE_HALF-1; phase toggles at wrap.
//   If autofire_en[p], fire[p][0] = raw & phase, else raw. Other buttons
//   unaffected. Enable change takes effect on the next registered output.
// - DIP: ioctl_wr && index==254 && addr[24:3]==0 && addr[2:0]<DIP_COUNT
//   -> dip[addr[2:0]] <= data. Otherwise ignored.
// - Game index: ioctl_wr && index==1 -> game_index <= data[3:0], any address.
// - Simultaneous PS/2 event and joystick change in one cycle: both take
//   effect (OR). reset_n low mid-operation clears everything immediately,
//   including DIPs; hence the power-on-only rule for reset_n.
//
// STRUCTURE
// - input_pkg: scancode localparams, joystick bit offsets as functions of
//   NUM_BUTTONS, typedef player_in_t {dir[3:0], fire[5:0], start, coin, pause}.
// - Sub-module ps2_keymap: toggle/primed logic and key-flag table; outputs
//   player_in_t for P0/P1. Coin, autofire and ioctl logic stay in top.
//
// TESTING
// - Reset release with ps2_key[10]=1 -> no key flag set; all outputs 0.
// - ps2_key={1,1,0,8'h75}, toggle flips -> dir[3] high 2 cycles later;
//   flip again with pressed=0 -> low.
// - joystick P1 bit 8 pulse 1 cycle, COIN_PULSE=16 -> coin[1] high exactly
//   16 cycles; retrigger at cycle 8 -> high until cycle 24.
// - autofire_en=01, AUTOFIRE_HALF=4, P0 button held -> fire[0] toggles every
//   4 cycles; fire[NUM_BUTTONS] (P1 b0) steady.
// - ioctl index 254, addr 1 data A5, addr 9 data FF -> dip byte1=A5,
//   others unchanged; index 1 data 3C -> game_index=C.
// - NUM_PLAYERS=4: joystick P3 pause -> pause=1; keyboard P0 pause OR'd too.

Source files
------------

// File: rtl/input_pkg.sv
// Shared definitions for the arcade input front end: PS/2 scancodes,
// joystick word bit positions and the per-player lane bundle.
package input_pkg;

   // Player 0 keyboard: arrows, Ctrl/Alt/Space, 1, 5, P
   localparam logic [7:0] SC_P0_UP    = 8'h75;
   localparam logic [7:0] SC_P0_DOWN  = 8'h72;
   localparam logic [7:0] SC_P0_LEFT  = 8'h6B;
   localparam logic [7:0] SC_P0_RIGHT = 8'h74;
   localparam logic [7:0] SC_P0_FIRE0 = 8'h14;
   localparam logic [7:0] SC_P0_FIRE1 = 8'h11;
   localparam logic [7:0] SC_P0_FIRE2 = 8'h29;
   localparam logic [7:0] SC_P0_START = 8'h16;
   localparam logic [7:0] SC_P0_COIN  = 8'h2E;
   localparam logic [7:0] SC_PAUSE    = 8'h4D;

   // Player 1 keyboard: R/F/D/G, A/S/Q, 2, 6
   localparam logic [7:0] SC_P1_UP    = 8'h2D;
   localparam logic [7:0] SC_P1_DOWN  = 8'h2B;
   localparam logic [7:0] SC_P1_LEFT  = 8'h23;
   localparam logic [7:0] SC_P1_RIGHT = 8'h34;
   localparam logic [7:0] SC_P1_FIRE0 = 8'h1C;
   localparam logic [7:0] SC_P1_FIRE1 = 8'h1B;
   localparam logic [7:0] SC_P1_FIRE2 = 8'h15;
   localparam logic [7:0] SC_P1_START = 8'h1E;
   localparam logic [7:0] SC_P1_COIN  = 8'h36;

   // Joystick word layout from hps_io
   localparam int JOY_RIGHT = 0;
   localparam int JOY_LEFT  = 1;
   localparam int JOY_DOWN  = 2;
   localparam int JOY_UP    = 3;
   localparam int JOY_FIRE0 = 4;

   function automatic int joy_start(input int nb);
      return JOY_FIRE0 + nb;
   endfunction

   function automatic int joy_coin(input int nb);
      return JOY_FIRE0 + nb + 1;
   endfunction

   function automatic int joy_pause(input int nb);
      return JOY_FIRE0 + nb + 2;
   endfunction

   // Output direction nibble order is {up,down,right,left}
   localparam int DIR_LEFT  = 0;
   localparam int DIR_RIGHT = 1;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_UP    = 3;

   localparam logic [7:0] IOCTL_IDX_GAME = 8'd1;
   localparam logic [7:0] IOCTL_IDX_DIP  = 8'd254;

   typedef struct packed {
      logic [3:0] dir;
      logic [5:0] fire;
      logic       start;
      logic       coin;
      logic       pause;
   } player_in_t;

   typedef enum logic {
      KM_UNPRIMED = 1'b0,
      KM_ARMED    = 1'b1
   } keymap_state_t;

endpackage

// File: rtl/ps2_keymap.sv
// PS/2 key event decoder: turns toggle-framed scancodes into held key flags
// for players 0 and 1.
//
// state       | meaning
// KM_UNPRIMED | first cycle out of reset; capture toggle, never an event
// KM_ARMED    | toggle change = key event, updates the matching flag
module ps2_keymap
   import input_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [10:0] i_ps2_key,
   output player_in_t  o_p0,
   output player_in_t  o_p1
);

   keymap_state_t r_state;
   logic          r_old_toggle;
   player_in_t    r_p0;
   player_in_t    r_p1;

   logic       w_toggle;
   logic       w_pressed;
   logic [7:0] w_code;
   logic       w_unused_ext;

   assign w_toggle     = i_ps2_key[10];
   assign w_pressed    = i_ps2_key[9];
   assign w_code       = i_ps2_key[7:0];
   assign w_unused_ext = i_ps2_key[8];

   // Prime on the first cycle, then latch press/release into the key flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= KM_UNPRIMED;
         r_old_toggle <= 1'b0;
         r_p0         <= '0;
         r_p1         <= '0;
      end else begin
         case (r_state)
            KM_UNPRIMED: begin
               r_state      <= KM_ARMED;
               r_old_toggle <= w_toggle;
            end
            KM_ARMED: begin
               if (w_toggle != r_old_toggle) begin
                  r_old_toggle <= w_toggle;
                  case (w_code)
                     SC_P0_UP:    r_p0.dir[DIR_UP]    <= w_pressed;
                     SC_P0_DOWN:  r_p0.dir[DIR_DOWN]  <= w_pressed;
                     SC_P0_LEFT:  r_p0.dir[DIR_LEFT]  <= w_pressed;
                     SC_P0_RIGHT: r_p0.dir[DIR_RIGHT] <= w_pressed;
                     SC_P0_FIRE0: r_p0.fire[0]        <= w_pressed;
                     SC_P0_FIRE1: r_p0.fire[1]        <= w_pressed;
                     SC_P0_FIRE2: r_p0.fire[2]        <= w_pressed;
                     SC_P0_START: r_p0.start          <= w_pressed;
                     SC_P0_COIN:  r_p0.coin           <= w_pressed;
                     SC_PAUSE:    r_p0.pause          <= w_pressed;
                     SC_P1_UP:    r_p1.dir[DIR_UP]    <= w_pressed;
                     SC_P1_DOWN:  r_p1.dir[DIR_DOWN]  <= w_pressed;
                     SC_P1_LEFT:  r_p1.dir[DIR_LEFT]  <= w_pressed;
                     SC_P1_RIGHT: r_p1.dir[DIR_RIGHT] <= w_pressed;
                     SC_P1_FIRE0: r_p1.fire[0]        <= w_pressed;
                     SC_P1_FIRE1: r_p1.fire[1]        <= w_pressed;
                     SC_P1_FIRE2: r_p1.fire[2]        <= w_pressed;
                     SC_P1_START: r_p1.start          <= w_pressed;
                     SC_P1_COIN:  r_p1.coin           <= w_pressed;
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   assign o_p0 = r_p0;
   assign o_p1 = r_p1;

endmodule

// File: rtl/input_mapper.sv
// Player input front end: merges keyboard flags and joystick words into
// registered per-player lanes with coin stretching, autofire, DIP bytes and
// game index capture from ioctl.
module input_mapper
   import input_pkg::*;
#(
   parameter int NUM_PLAYERS   = 2,
   parameter int NUM_BUTTONS   = 3,
   parameter int COIN_PULSE    = 960000,
   parameter int AUTOFIRE_HALF = 1600000,
   parameter int DIP_COUNT     = 8
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic [10:0]                            ps2_key,
   input  logic [NUM_PLAYERS*(7+NUM_BUTTONS)-1:0] joystick,
   input  logic [NUM_PLAYERS-1:0]                 autofire_en,
   input  logic                                   ioctl_wr,
   input  logic [7:0]                             ioctl_index,
   input  logic [24:0]                            ioctl_addr,
   input  logic [7:0]                             ioctl_data,
   output logic [NUM_PLAYERS*4-1:0]               dir,
   output logic [NUM_PLAYERS*NUM_BUTTONS-1:0]     fire,
   output logic [NUM_PLAYERS-1:0]                 start,
   output logic [NUM_PLAYERS-1:0]                 coin,
   output logic                                   pause,
   output logic [DIP_COUNT*8-1:0]                 dip,
   output logic [3:0]                             game_index
);

   localparam int JOY_W = 7 + NUM_BUTTONS;
   localparam int CW    = (COIN_PULSE < 2) ? 1 : $clog2(COIN_PULSE);
   localparam int AW    = (AUTOFIRE_HALF < 2) ? 1 : $clog2(AUTOFIRE_HALF);

   // The raw-high cycle itself counts toward the pulse, so load one less
   localparam logic [CW-1:0] COIN_LOAD = (COIN_PULSE == 0) ? '0 : CW'(COIN_PULSE - 1);
   localparam logic [AW-1:0] AF_LAST   = AW'(AUTOFIRE_HALF - 1);

   player_in_t w_kb_p0;
   player_in_t w_kb_p1;
   player_in_t w_kb_sel;
   logic [JOY_W-1:0] w_joy_sel;

   logic [3:0]             w_dir  [NUM_PLAYERS];
   logic [NUM_BUTTONS-1:0] w_fire [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] w_start;
   logic [NUM_PLAYERS-1:0] w_coin;
   logic [NUM_PLAYERS-1:0] w_pause;
   logic                   w_dip_we;
   logic                   w_unused_kb;

   logic [CW-1:0]          r_coin_cnt [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] r_coin_prev;
   logic [AW-1:0]          r_af_cnt;
   logic                   r_af_phase;

   ps2_keymap u_keymap (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_ps2_key (ps2_key),
      .o_p0      (w_kb_p0),
      .o_p1      (w_kb_p1)
   );

   // Keyboard fire keys beyond NUM_BUTTONS and P1 keys with one player are dropped
   assign w_unused_kb = ^{w_kb_p0.fire, w_kb_p1};

   // Raw lanes: keyboard flag OR joystick bit, autofire gating on button 0
   always_comb begin
      w_kb_sel  = '0;
      w_joy_sel = '0;
      w_dir     = '{default: '0};
      w_fire    = '{default: '0};
      w_start   = '0;
      w_coin    = '0;
      w_pause   = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (p == 0)      w_kb_sel = w_kb_p0;
         else if (p == 1) w_kb_sel = w_kb_p1;
         else             w_kb_sel = '0;
         w_joy_sel = joystick[p*JOY_W +: JOY_W];
         w_dir[p][DIR_UP]    = w_kb_sel.dir[DIR_UP]    | w_joy_sel[JOY_UP];
         w_dir[p][DIR_DOWN]  = w_kb_sel.dir[DIR_DOWN]  | w_joy_sel[JOY_DOWN];
         w_dir[p][DIR_RIGHT] = w_kb_sel.dir[DIR_RIGHT] | w_joy_sel[JOY_RIGHT];
         w_dir[p][DIR_LEFT]  = w_kb_sel.dir[DIR_LEFT]  | w_joy_sel[JOY_LEFT];
         w_fire[p]    = w_kb_sel.fire[NUM_BUTTONS-1:0] | w_joy_sel[JOY_FIRE0 +: NUM_BUTTONS];
         w_fire[p][0] = w_fire[p][0] & (r_af_phase | ~autofire_en[p]);
         w_start[p]   = w_kb_sel.start | w_joy_sel[joy_start(NUM_BUTTONS)];
         w_coin[p]    = w_kb_sel.coin  | w_joy_sel[joy_coin(NUM_BUTTONS)];
         w_pause[p]   = w_kb_sel.pause | w_joy_sel[joy_pause(NUM_BUTTONS)];
      end
   end

   // Register direction, fire, start and global pause lanes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dir   <= '0;
         fire  <= '0;
         start <= '0;
         pause <= 1'b0;
      end else begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            dir[p*4 +: 4]                    <= w_dir[p];
            fire[p*NUM_BUTTONS +: NUM_BUTTONS] <= w_fire[p];
         end
         start <= w_start;
         pause <= |w_pause;
      end
   end

   // Coin stretch: rising raw edge (re)loads the per-player down-counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         coin        <= '0;
         r_coin_prev <= '0;
         for (int p = 0; p < NUM_PLAYERS; p++) r_coin_cnt[p] <= '0;
      end else begin
         r_coin_prev <= w_coin;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_coin[p] && !r_coin_prev[p])
               r_coin_cnt[p] <= COIN_LOAD;
            else if (r_coin_cnt[p] != '0)
               r_coin_cnt[p] <= r_coin_cnt[p] - CW'(1);
            coin[p] <= w_coin[p] | (r_coin_cnt[p] != '0);
         end
      end
   end

   // Shared autofire square wave, phase starts high out of reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_af_cnt   <= '0;
         r_af_phase <= 1'b1;
      end else if (r_af_cnt == AF_LAST) begin
         r_af_cnt   <= '0;
         r_af_phase <= ~r_af_phase;
      end else begin
         r_af_cnt <= r_af_cnt + AW'(1);
      end
   end

   assign w_dip_we = ioctl_wr && (ioctl_index == IOCTL_IDX_DIP) && (ioctl_addr[24:3] == '0);

   // DIP bytes and game variant captured from ioctl writes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dip        <= '0;
         game_index <= '0;
      end else begin
         for (int i = 0; i < DIP_COUNT; i++) begin
            if (w_dip_we && (ioctl_addr[2:0] == 3'(i)))
               dip[i*8 +: 8] <= ioctl_data;
         end
         if (ioctl_wr && (ioctl_index == IOCTL_IDX_GAME))
            game_index <= ioctl_data[3:0];
      end
   end

endmodule

// File: tb/tb_input_mapper.sv
// Bench for input_mapper: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the input rules.
module tb_input_mapper;

   localparam int NP = 4;
   localparam int NB = 3;
   localparam int CP = 16;
   localparam int AH = 4;
   localparam int DC = 6;
   localparam int JW = 7 + NB;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [10:0]       ps2_key = '0;
   logic [NP*JW-1:0]  joystick = '0;
   logic [NP-1:0]     autofire_en = '0;
   logic              ioctl_wr = 1'b0;
   logic [7:0]        ioctl_index = '0;
   logic [24:0]       ioctl_addr = '0;
   logic [7:0]        ioctl_data = '0;
   logic [NP*4-1:0]   dir;
   logic [NP*NB-1:0]  fire;
   logic [NP-1:0]     start;
   logic [NP-1:0]     coin;
   logic              pause;
   logic [DC*8-1:0]   dip;
   logic [3:0]        game_index;

   input_mapper #(
      .NUM_PLAYERS(NP), .NUM_BUTTONS(NB), .COIN_PULSE(CP),
      .AUTOFIRE_HALF(AH), .DIP_COUNT(DC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
      .autofire_en(autofire_en), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
      .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .dir(dir), .fire(fire),
      .start(start), .coin(coin), .pause(pause), .dip(dip), .game_index(game_index)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- reference model ----------------
   // Per-player lane vector: [3:0] {up,down,right,left}, [9:4] fire, 10 start, 11 coin, 12 pause
   int          n_edge;
   bit          m_primed;
   logic        m_old;
   logic [12:0] m_kb [2];
   logic        m_prev_coin [NP];
   int          m_until [NP];
   logic [7:0]  m_dip [DC];
   logic [3:0]  m_game;
   logic [12:0] m_raw;
   logic        m_ph;
   int          m_k;

   logic [NP*4-1:0]  e_dir;
   logic [NP*NB-1:0] e_fire;
   logic [NP-1:0]    e_start, e_coin;
   logic             e_pause;
   logic [DC*8-1:0]  e_dip;
   logic [3:0]       e_game;

   logic [88:0] w_act, w_exp;
   assign w_act = {dir, fire, start, coin, pause, dip, game_index};
   assign w_exp = {e_dir, e_fire, e_start, e_coin, e_pause, e_dip, e_game};

   function automatic int key_lane(input logic [7:0] code);
      case (code)
         8'h75: return 3;       8'h72: return 2;       8'h74: return 1;       8'h6B: return 0;
         8'h14: return 4;       8'h11: return 5;       8'h29: return 6;
         8'h16: return 10;      8'h2E: return 11;      8'h4D: return 12;
         8'h2D: return 16 + 3;  8'h2B: return 16 + 2;  8'h34: return 16 + 1;  8'h23: return 16 + 0;
         8'h1C: return 16 + 4;  8'h1B: return 16 + 5;  8'h15: return 16 + 6;
         8'h1E: return 16 + 10; 8'h36: return 16 + 11;
         default: return -1;
      endcase
   endfunction

   function automatic logic [12:0] joy_lanes(input logic [JW-1:0] j);
      return {j[9], j[8], j[7], 3'b000, j[6:4], j[3], j[2], j[0], j[1]};
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_edge = 0; m_primed = 0; m_old = 0;
         m_kb[0] = '0; m_kb[1] = '0; m_game = '0;
         for (int p = 0; p < NP; p++) begin m_prev_coin[p] = 0; m_until[p] = 0; end
         for (int i = 0; i < DC; i++) m_dip[i] = '0;
         e_dir = '0; e_fire = '0; e_start = '0; e_coin = '0; e_pause = 0; e_dip = '0; e_game = '0;
      end else begin
         n_edge++;
         m_ph = ((((n_edge - 1) / AH) % 2) == 0);
         e_pause = 0;
         for (int p = 0; p < NP; p++) begin
            m_raw = joy_lanes(joystick[p*JW +: JW]) | ((p < 2) ? m_kb[p % 2] : 13'h0);
            e_dir[p*4 +: 4]   = m_raw[3:0];
            e_fire[p*NB +: NB] = m_raw[6:4];
            if (autofire_en[p]) e_fire[p*NB] = m_raw[4] & m_ph;
            e_start[p] = m_raw[10];
            if (m_raw[11] && !m_prev_coin[p]) m_until[p] = n_edge + CP;
            m_prev_coin[p] = m_raw[11];
            e_coin[p] = m_raw[11] | (n_edge < m_until[p]);
            e_pause = e_pause | m_raw[12];
         end
         if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'(DC)) m_dip[ioctl_addr[2:0]] = ioctl_data;
         if (ioctl_wr && ioctl_index == 8'd1) m_game = ioctl_data[3:0];
         for (int i = 0; i < DC; i++) e_dip[i*8 +: 8] = m_dip[i];
         e_game = m_game;
         if (!m_primed) begin
            m_primed = 1; m_old = ps2_key[10];
         end else if (ps2_key[10] != m_old) begin
            m_old = ps2_key[10];
            m_k = key_lane(ps2_key[7:0]);
            if (m_k >= 0) m_kb[m_k / 16][m_k % 16] = ps2_key[9];
         end
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 0; ps2_key = 11'h400;
      repeat (3) @(negedge clk);
      n_checks++;
      if (w_act !== '0) $display("FAIL reset_hold: got %h want 0", w_act); else n_pass++;
      reset_n = 1;
      repeat (4) begin
         @(negedge clk);
         n_checks++;
         if (w_act !== w_exp) $display("FAIL reset_model: got %h want %h", w_act, w_exp); else n_pass++;
      end
      n_checks++;
      if (w_act !== '0) $display("FAIL reset_no_keyflag: got %h want 0", w_act); else n_pass++;
   endtask

   task automatic test_ps2_arrow();
      ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h75};
      @(negedge clk);
      n_checks++;
      if (dir[3] !== 1'b0) $display("FAIL ps2_early: got %b want 0", dir[3]); else n_pass++;
      @(negedge clk);
      n_checks++;
      if (dir !== 16'h0008) $display("FAIL ps2_press: got %h want 0008", dir); else n_pass++;
      ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h75};
      repeat (2) @(negedge clk);
      n_checks++;
      if (dir !== 16'h0000) $display("FAIL ps2_release: got %h want 0000", dir); else n_pass++;
   endtask

   task automatic test_coin();
      int hi;
      int first_low;
      for (int pass = 0; pass < 2; pass++) begin
         hi = 0; first_low = -1;
         joystick[1*JW + 8] = 1'b1;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_checks++;
            if (w_act !== w_exp) $display("FAIL coin_model: cyc %0d got %h want %h", i, w_act, w_exp); else n_pass++;
            if (coin[1]) hi++; else if (first_low < 0) first_low = i;
            if (i == 0 || i == 8) joystick[1*JW + 8] = 1'b0;
            if (pass == 1 && i == 7) joystick[1*JW + 8] = 1'b1;
         end
         n_checks++;
         if (hi != 16 + 8*pass || first_low != 16 + 8*pass)
            $display("FAIL coin_width: pass %0d got %0d high, low at %0d want %0d", pass, hi, first_low, 16 + 8*pass);
         else n_pass++;
      end
   endtask

   task automatic test_autofire();
      logic s [20];
      autofire_en = 4'b0001;
      joystick[0*JW + 4] = 1'b1;
      joystick[1*JW + 4] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         s[i] = fire[0];
         n_checks++;
         if (w_act !== w_exp) $display("FAIL af_model: cyc %0d got %h want %h", i, w_act, w_exp); else n_pass++;
         n_checks++;
         if (fire[NB] !== 1'b1) $display("FAIL af_p1_steady: cyc %0d got %b want 1", i, fire[NB]); else n_pass++;
         if (i >= 4) begin
            n_checks++;
            if (s[i] === s[i-4]) $display("FAIL af_period: cyc %0d got %b want %b", i, s[i], ~s[i-4]); else n_pass++;
         end
      end
      joystick = '0;
      autofire_en = '0;
      @(negedge clk);
   endtask

   task automatic test_ioctl();
      logic [7:0]  idx  [5] = '{8'd254, 8'd254, 8'd254, 8'd1, 8'd254};
      logic [24:0] adr  [5] = '{25'd1, 25'd9, 25'd6, 25'd77, 25'h100001};
      logic [7:0]  dat  [5] = '{8'hA5, 8'hFF, 8'h77, 8'h3C, 8'h11};
      for (int w = 0; w < 5; w++) begin
         ioctl_wr = 1; ioctl_index = idx[w]; ioctl_addr = adr[w]; ioctl_data = dat[w];
         @(negedge clk);
         ioctl_wr = 0;
         n_checks++;
         if (w_act !== w_exp) $display("FAIL ioctl_model: wr %0d got %h want %h", w, w_act, w_exp); else n_pass++;
      end
      n_checks++;
      if (dip !== 48'h0000_0000_A500) $display("FAIL dip_bytes: got %h want 00000000a500", dip); else n_pass++;
      n_checks++;
      if (game_index !== 4'hC) $display("FAIL game_index: got %h want c", game_index); else n_pass++;
   endtask

   task automatic test_pause4();
      joystick[3*JW + 9] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (pause !== 1'b1) $display("FAIL pause_joy_p3: got %b want 1", pause); else n_pass++;
      joystick[3*JW + 9] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (pause !== 1'b0) $display("FAIL pause_clear: got %b want 0", pause); else n_pass++;
      ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h4D};
      repeat (2) @(negedge clk);
      n_checks++;
      if (pause !== 1'b1) $display("FAIL pause_kb: got %b want 1", pause); else n_pass++;
      ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h4D};
      repeat (2) @(negedge clk);
      n_checks++;
      if (w_act !== w_exp) $display("FAIL pause_model: got %h want %h", w_act, w_exp); else n_pass++;
   endtask

   task automatic test_simultaneous();
      ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h16};
      joystick[0*JW + 3] = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({dir[3], start[0]} !== 2'b10) $display("FAIL simul_first: got %b want 10", {dir[3], start[0]}); else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({dir[3], start[0]} !== 2'b11) $display("FAIL simul_both: got %b want 11", {dir[3], start[0]}); else n_pass++;
      ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h16};
      joystick = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      logic [7:0]  codes [19] = '{8'h75, 8'h72, 8'h74, 8'h6B, 8'h14, 8'h11, 8'h29, 8'h16, 8'h2E, 8'h4D,
                                  8'h2D, 8'h2B, 8'h34, 8'h23, 8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h36};
      logic [7:0]  idxs [4] = '{8'd1, 8'd254, 8'd0, 8'd253};
      logic [63:0] r64;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         n_checks++;
         if (w_act !== w_exp) $display("FAIL random_model: cyc %0d got %h want %h", c, w_act, w_exp); else n_pass++;
         r64 = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         joystick = joystick ^ r64[NP*JW-1:0];
         if ($urandom_range(0, 5) == 0) begin
            ps2_key[10]  = ~ps2_key[10];
            ps2_key[9]   = 1'($urandom_range(0, 1));
            ps2_key[8]   = 1'($urandom_range(0, 1));
            ps2_key[7:0] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : codes[$urandom_range(0, 18)];
         end
         if ($urandom_range(0, 31) == 0) autofire_en = 4'($urandom);
         ioctl_wr    = ($urandom_range(0, 7) == 0);
         ioctl_index = idxs[$urandom_range(0, 3)];
         ioctl_addr  = ($urandom_range(0, 3) == 0) ? 25'($urandom) : 25'($urandom_range(0, 9));
         ioctl_data  = 8'($urandom);
      end
      ioctl_wr = 0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      #2 reset_n = 0;
      #1;
      n_checks++;
      if (w_act !== '0) $display("FAIL reset_async: got %h want 0", w_act); else n_pass++;
      @(negedge clk);
      reset_n = 1;
      repeat (10) begin
         @(negedge clk);
         n_checks++;
         if (w_act !== w_exp) $display("FAIL reset_mid_model: got %h want %h", w_act, w_exp); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_ps2_arrow();
      test_coin();
      test_autofire();
      test_ioctl();
      test_pause4();
      test_simultaneous();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
